// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - FSM state encoding (RUN / BR_WAIT)
//   - default register-index width
//   - architectural zero register index (never a real dependency)
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } hz_state_e;

  localparam int REG_W_DEF = 5;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hold/bubble/flush generator for the 5-stage MIPS pipeline. Resolves cache
// stalls (Freeze), load-use and ID-branch operand hazards (Bubble) and taken
// branch flushes. Outputs are Mealy: combinational from state and inputs.
//
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt  source operands of the instruction in ID
//   id_branch, id_br_taken    branch in ID and its resolved direction
//   ex_cache_read, ex_reg_write, ex_dst   EX-stage producer info
//   mem_cache_read, mem_dst   MEM-stage load info
//   icache_stall, dcache_stall  cache busy
//   pc_hold..memwb_hold       hold stage registers (1 = keep contents)
//   idex_nop                  zero ID/EX control fields
//   ifid_flush                flush IF/ID on taken branch
//   state_o                   FSM state (0 = RUN, 1 = BR_WAIT)
//
// Optional: define HAZ_PERF_CNT_EN to add saturating 32-bit counters
// perf_cstall_cyc, perf_bubbles, perf_flushes.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_br_taken,
  input  logic             ex_cache_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_cache_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             memwb_hold,
  output logic             idex_nop,
  output logic             ifid_flush,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]      perf_cstall_cyc,
  output logic [31:0]      perf_bubbles,
  output logic [31:0]      perf_flushes,
`endif
  output logic             state_o
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  hz_state_e state_q, state_d;

  logic match_ex, match_mem, cstall;
  logic lu, bex, bmem, bld;
  logic bubble, freeze, flush;

  // Writes to the zero register never create a dependency.
  assign match_ex  = (ex_dst != ZERO_IDX) &&
                     ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
  assign match_mem = (mem_dst != ZERO_IDX) &&
                     ((mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));
  assign cstall    = icache_stall | dcache_stall;

  assign lu   = ex_cache_read & match_ex;
  assign bex  = id_branch & ex_reg_write & match_ex;
  assign bmem = id_branch & mem_cache_read & match_mem;
  assign bld  = id_branch & ex_cache_read & match_ex;

  always_comb begin
    state_d = state_q;
    bubble  = 1'b0;
    freeze  = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cstall) begin
          freeze = 1'b1;
        end else if (bld) begin
          // Load result reaches the ID comparator two cycles later.
          bubble  = 1'b1;
          state_d = BR_WAIT;
        end else if (lu | bex | bmem) begin
          bubble = 1'b1;
        end else if (id_branch & id_br_taken) begin
          flush = 1'b1;
        end
      end
      BR_WAIT: begin
        if (cstall) begin
          freeze = 1'b1;
        end else begin
          // Second bubble of the load->branch sequence; hazards are
          // re-examined in RUN next cycle.
          bubble  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset forces every control low regardless of inputs.
    if (rst) begin
      bubble = 1'b0;
      freeze = 1'b0;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign pc_hold    = bubble | freeze;
  assign ifid_hold  = bubble | freeze;
  assign idex_hold  = freeze;
  assign exmem_hold = freeze;
  assign memwb_hold = freeze;
  assign idex_nop   = bubble;
  assign ifid_flush = flush;
  assign state_o    = rst ? 1'b0 : (state_q == BR_WAIT);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] cstall_q, bubbles_q, flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstall_q  <= '0;
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      if (freeze && cstall_q  != '1) cstall_q  <= cstall_q + 32'd1;
      if (bubble && bubbles_q != '1) bubbles_q <= bubbles_q + 32'd1;
      if (flush  && flushes_q != '1) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_cstall_cyc = cstall_q;
  assign perf_bubbles    = bubbles_q;
  assign perf_flushes    = flushes_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int REG_W = 5;

  // Packed view of the controls: {pc,ifid,idex,exmem,memwb,nop,flush,state}
  localparam logic [7:0] IDLE   = 8'b0000_0000;
  localparam logic [7:0] BUB_RN = 8'b1100_0100;
  localparam logic [7:0] BUB_BW = 8'b1100_0101;
  localparam logic [7:0] FRZ_RN = 8'b1111_1000;
  localparam logic [7:0] FRZ_BW = 8'b1111_1001;
  localparam logic [7:0] FLUSH  = 8'b0000_0010;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic id_uses_rt, id_branch, id_br_taken, ex_cache_read, ex_reg_write;
  logic mem_cache_read, icache_stall, dcache_stall;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
  logic idex_nop, ifid_flush, state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_cstall_cyc, perf_bubbles, perf_flushes;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken),
    .ex_cache_read(ex_cache_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .mem_cache_read(mem_cache_read), .mem_dst(mem_dst),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
    .idex_nop(idex_nop), .ifid_flush(ifid_flush),
`ifdef HAZ_PERF_CNT_EN
    .perf_cstall_cyc(perf_cstall_cyc), .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes),
`endif
    .state_o(state_o)
  );

  wire [7:0] ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                    idex_nop, ifid_flush, state_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; id_uses_rt = 0; id_branch = 0; id_br_taken = 0;
    ex_cache_read = 0; ex_reg_write = 0; ex_dst = '0;
    mem_cache_read = 0; mem_dst = '0; icache_stall = 0; dcache_stall = 0;
  endtask

  // Advance one clock; inputs change and checks happen 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    // Hazard present during reset must not leak to the outputs.
    ex_cache_read = 1; ex_dst = 5'd8; id_rs = 5'd8; dcache_stall = 1;
    step(); step();
    chk("reset_ctl", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZ_PERF_CNT_EN
    chk("reset_cnt", perf_cstall_cyc | perf_bubbles | perf_flushes, 32'd0);
`endif
    clr();
    @(negedge clk); rst = 0;
    step();
    chk("idle", {24'd0, ctl}, {24'd0, IDLE});

    // Load-use, non-branch: single bubble.
    ex_cache_read = 1; ex_dst = 5'd8; id_rs = 5'd8; #1;
    chk("lu_bub", {24'd0, ctl}, {24'd0, BUB_RN});
    step();
    ex_cache_read = 0; mem_cache_read = 1; mem_dst = 5'd8; #1;
    chk("lu_done", {24'd0, ctl}, {24'd0, IDLE});
    step(); clr(); #1;

    // Load feeding a taken branch via rt: two bubbles, flush afterwards.
    ex_cache_read = 1; ex_reg_write = 1; ex_dst = 5'd9; id_rt = 5'd9;
    id_uses_rt = 1; id_branch = 1; id_br_taken = 1; #1;
    chk("bld_bub1", {24'd0, ctl}, {24'd0, BUB_RN});
    step();
    ex_cache_read = 0; ex_reg_write = 0; mem_cache_read = 1; mem_dst = 5'd9; #1;
    chk("bld_bub2", {24'd0, ctl}, {24'd0, BUB_BW});
    step();
    mem_cache_read = 0; #1;
    chk("bld_flush", {24'd0, ctl}, {24'd0, FLUSH});
    step(); clr(); #1;

    // dcache stall over load-use: 5 Freeze then 1 Bubble.
    ex_cache_read = 1; ex_dst = 5'd3; id_rs = 5'd3; dcache_stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("dc_frz%0d", i), {24'd0, ctl}, {24'd0, FRZ_RN});
      step();
    end
    dcache_stall = 0; #1;
    chk("dc_bub", {24'd0, ctl}, {24'd0, BUB_RN});
    step(); clr(); #1;

    // icache stall stretches BR_WAIT.
    ex_cache_read = 1; ex_dst = 5'd4; id_rs = 5'd4; id_branch = 1; #1;
    chk("bw_enter", {24'd0, ctl}, {24'd0, BUB_RN});
    step();
    clr(); id_branch = 1; icache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bw_frz%0d", i), {24'd0, ctl}, {24'd0, FRZ_BW});
      step();
    end
    icache_stall = 0; #1;
    chk("bw_bub", {24'd0, ctl}, {24'd0, BUB_BW});
    step();
    chk("bw_run", {24'd0, ctl}, {24'd0, IDLE});
    clr();

    // Taken branch with no hazard: flush; zero-register writer ignored.
    id_branch = 1; id_br_taken = 1; id_rs = 5'd2; #1;
    chk("flush", {24'd0, ctl}, {24'd0, FLUSH});
    step(); clr(); #1;
    chk("flush_off", {24'd0, ctl}, {24'd0, IDLE});
    id_branch = 1; id_br_taken = 1; ex_cache_read = 1; ex_reg_write = 1;
    ex_dst = 5'd0; id_rs = 5'd0; #1;
    chk("r0_flush", {24'd0, ctl}, {24'd0, FLUSH});
    step(); clr(); #1;

    // ALU result feeding a branch: one bubble, stays in RUN.
    id_branch = 1; ex_reg_write = 1; ex_dst = 5'd5; id_rs = 5'd5; #1;
    chk("bex_bub", {24'd0, ctl}, {24'd0, BUB_RN});
    step(); clr(); #1;
    chk("bex_run", {24'd0, ctl}, {24'd0, IDLE});

    // Load in MEM feeding branch rt; rt unused masks the match.
    id_branch = 1; mem_cache_read = 1; mem_dst = 5'd7; id_rt = 5'd7;
    id_uses_rt = 1; #1;
    chk("bmem_bub", {24'd0, ctl}, {24'd0, BUB_RN});
    id_uses_rt = 0; #1;
    chk("bmem_nort", {24'd0, ctl}, {24'd0, IDLE});
    step(); clr(); #1;

    // Reset asserted in BR_WAIT clears immediately, nothing pending after.
    id_branch = 1; ex_cache_read = 1; ex_dst = 5'd6; id_rs = 5'd6;
    step();
    clr(); #1;
    chk("rst_pre", {24'd0, ctl}, {24'd0, BUB_BW});
    rst = 1; #1;
    chk("rst_async", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZ_PERF_CNT_EN
    chk("rst_cnt", perf_cstall_cyc | perf_bubbles | perf_flushes, 32'd0);
`endif
    step();
    @(negedge clk); rst = 0;
    step();
    chk("rst_after", {24'd0, ctl}, {24'd0, IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
